// File: rtl/cook_sequencer.sv
// cook_sequencer -- oven cook controller.
//   Clocked FSM (IDLE/COOK/PAUSE/DONE) that drives the magnetron enable and
//   the countdown timer strobes from the panel buttons, door switch and the
//   timer-zero flag.
// Configuration macro:
//   DONE_BEEP_EN  when defined, beep_o is high for BEEP_TICKS ticks after
//                 entering DONE; when undefined, beep_o is tied low.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   startn_i/stopn_i/clrn_i  debounced active-low buttons
//   door_closed_i    1 = door closed
//   tick_i           1-cycle 1 Hz timebase pulse
//   timer_zero_i     countdown timer is at 0
//   mag_on_o         magnetron enable
//   timer_dec_o      1-cycle decrement strobe to the timer
//   timer_clr_o      1-cycle clear strobe to the timer
//   state_o          00 IDLE, 01 COOK, 10 PAUSE, 11 DONE
//   beep_o           done beeper
module cook_sequencer #(
   parameter int PAUSE_TIMEOUT = 60,
   parameter int BEEP_TICKS    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       startn_i,
   input  logic       stopn_i,
   input  logic       clrn_i,
   input  logic       door_closed_i,
   input  logic       tick_i,
   input  logic       timer_zero_i,
   output logic       mag_on_o,
   output logic       timer_dec_o,
   output logic       timer_clr_o,
   output logic [1:0] state_o,
   output logic       beep_o
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_COOK  = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   localparam logic [7:0] TO_M1 = 8'(PAUSE_TIMEOUT - 1);

   if (PAUSE_TIMEOUT < 1 || PAUSE_TIMEOUT > 255) begin : g_bad_timeout
      $error("cook_sequencer: PAUSE_TIMEOUT out of range 1..255");
   end
   if (BEEP_TICKS < 1 || BEEP_TICKS > 15) begin : g_bad_beep
      $error("cook_sequencer: BEEP_TICKS out of range 1..15");
   end

   // Button edge detect: bit 0 start, bit 1 stop, bit 2 clr.
   // press_q is the registered falling edge, so a held button is one press.
   logic [2:0] btn_now;
   logic [2:0] btn_q;
   logic [2:0] press_q;

   assign btn_now = {clrn_i, stopn_i, startn_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q   <= 3'b111;
         press_q <= 3'b000;
      end else begin
         btn_q   <= btn_now;
         press_q <= btn_q & ~btn_now;
      end
   end

   logic [1:0] state_q, state_d;
   logic [7:0] pcnt_q, pcnt_d;
   logic       clr_q, clr_d;

   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press_q[0] && door_closed_i && !timer_zero_i) state_d = S_COOK;
            else if (press_q[2])                              clr_d   = 1'b1;
         end
         S_COOK: begin
            // timer_zero outranks door and stop
            if (timer_zero_i)                     state_d = S_DONE;
            else if (!door_closed_i || press_q[1]) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            // a start press beats both abort paths, including the timeout
            if (press_q[0] && door_closed_i) begin
               state_d = S_COOK;
            end else if (press_q[1] || press_q[2]) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end else if (tick_i && pcnt_q == TO_M1) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end
         end
         S_DONE: begin
            if ((|press_q) || !door_closed_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pause tick counter only runs while we stay in PAUSE; any other path zeroes it.
   always_comb begin
      pcnt_d = 8'd0;
      if (state_q == S_PAUSE && state_d == S_PAUSE) pcnt_d = pcnt_q + {7'd0, tick_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pcnt_q  <= 8'd0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         clr_q   <= clr_d;
      end
   end

   // Door term is combinational so the magnetron drops the cycle the door opens.
   assign mag_on_o    = (state_q == S_COOK) & door_closed_i;
   assign timer_dec_o = (state_q == S_COOK) & door_closed_i & tick_i;
   // clr_q is only set when the next state is IDLE, so it never overlaps timer_dec_o.
   assign timer_clr_o = clr_q;
   assign state_o     = state_q;

`ifdef DONE_BEEP_EN
   localparam logic [3:0] BT_M1 = 4'(BEEP_TICKS - 1);
   logic       beep_q;
   logic [3:0] bcnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beep_q <= 1'b0;
         bcnt_q <= 4'd0;
      end else if (state_d != S_DONE) begin
         beep_q <= 1'b0;
         bcnt_q <= 4'd0;
      end else if (state_q != S_DONE) begin
         beep_q <= 1'b1;
         bcnt_q <= 4'd0;
      end else if (beep_q && tick_i) begin
         if (bcnt_q == BT_M1) beep_q <= 1'b0;
         bcnt_q <= bcnt_q + 4'd1;
      end
   end

   assign beep_o = beep_q;
`else
   assign beep_o = 1'b0;
`endif

endmodule
